ball_ctrl: RTL
==============

# ball_ctrl

Game-physics sequencer for the ball mover. Turns the per-frame tick into move strobes and checks walls, paddles and misses after every step. Reflects the 4-bit direction on each bounce, pulses score on a miss, and holds the mover in recentre reset until the next serve. It sits between the VGA frame timing, the paddle logic and the mover, and drives the mover's `move`, `direction` and `rst` inputs.

## Interface
- PAD_X, 64: distance of each paddle face from its side wall, quarter-pixel units
- PAD_HALF, 160: paddle half-height, quarter-pixel units
- MAX_STEPS, 4: maximum move strobes per frame (1..7)
- HITS_PER_STEP, 4: paddle hits per speed increment (used only with BALL_SPEEDUP_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- serve  in  1  one-cycle serve request
- ball_x  in  13  ball centre x from mover, 0..2559
- ball_y  in  13  ball centre y from mover, 0..1919
- size  in  13  ball half-size, same value fed to mover
- pad_l_y  in  13  left paddle centre y
- pad_r_y  in  13  right paddle centre y
- move  out  1  one-cycle step strobe to mover
- dir  out  4  direction to mover; 0=up, clockwise, 4=right, 8=down, 12=left
- ball_rst  out  1  mover recentre reset (synchronous at mover)
- score_l  out  1  one-cycle pulse: left player scores
- score_r  out  1  one-cycle pulse: right player scores
- in_play  out  1  high in all play states
- steps  out  3  current strobes per frame

## Operation
- States:
  - WAIT: ball_rst=1. serve → ball_rst=0, go to IDLE.
  - IDLE: frame_tick → load step count `steps`, go to STEP.
  - STEP: move=1 for exactly one cycle, go to SETTLE.
  - SETTLE: one cycle for the mover registers, go to CHECK.
  - CHECK: evaluate and update dir. Then: miss → SCORE; else remaining steps > 0 → STEP; else IDLE.
  - SCORE: pulse score_l or score_r for one cycle, clear rally, set serve dir, go to WAIT.
- Direction classes:
  - up = {13,14,15,0,1,2,3}; down = {5..11}
  - left = {9..15}; right = {1..7}
- Wall: bounces off the top/bottom walls.
  - Condition: ball_y <= size while moving up, or ball_y >= 1920-size while moving down.
  - Result: dir ← (8-dir) mod 16.
- Paddle, left: moving left and ball_x <= PAD_X+size, with vertical overlap.
  - Overlap: ball_y+size >= pad_l_y-PAD_HALF and ball_y-size <= pad_l_y+PAD_HALF.
  - Result: dir ← (16-dir) mod 16 and rally hit counter +1.
  - Right paddle mirrors this: moving right and ball_x >= 2560-PAD_X-size, overlap with pad_r_y.
- Miss: moving left and ball_x <= size → score_r; moving right and ball_x >= 2560-size → score_l.
- Priority and corners:
  - Miss beats paddle and wall.
  - Wall and paddle in the same CHECK apply both reflections: dir ← (dir+8) mod 16.
- Serve dir: 5 after reset; 11 after score_r (left conceded); 5 after score_l.
- Arithmetic: compute overlap and bound comparisons in 14-bit unsigned. Clamp negative paddle extents (pad-PAD_HALF < 0) to 0.

## Timing
- Reset values: state WAIT, move=0, dir=5, ball_rst=1, score_l=score_r=0, in_play=0, steps=1, rally=0.
- Latency:
  - frame_tick in IDLE → move high two cycles later (IDLE→STEP registered).
  - Each step takes 3 cycles (STEP, SETTLE, CHECK).
  - dir is updated at the end of CHECK and is valid for the following STEP.
- frame_tick outside IDLE is dropped, not queued.
- serve outside WAIT is ignored.
- serve and frame_tick together in WAIT: serve is taken, the tick is dropped.
- Reset mid-frame aborts the remaining steps immediately and returns to WAIT with ball_rst=1.
- Rally counter saturates at 255.

## Configuration
- BALL_SPEEDUP_EN defined: steps = min(1 + rally/HITS_PER_STEP, MAX_STEPS), sampled when entering STEP from IDLE.
- BALL_SPEEDUP_EN undefined: steps is constant 1. No rally divider is synthesised; the rally counter is still kept for the hit count.

## Structure
- Package ball_pkg holds:
  - FIELD_W=2560 and FIELD_H=1920
  - direction constants DIR_UP=0, DIR_RIGHT=4, DIR_DOWN=8, DIR_LEFT=12
  - the state encoding
  - up/down/left/right class functions
- One sub-module, ball_reflect: purely combinational. Inputs are the positions, size, paddles and dir; outputs are new_dir, hit, miss_l and miss_r.
- ball_ctrl holds the FSM, the step counter and the rally counter.

## Test plan
- Reset, then serve → ball_rst falls the next cycle, dir=5; frame_tick → exactly one move pulse, two cycles after the tick.
- dir=1, ball_y=size=16 at CHECK → dir=7; dir=6, ball_y=1904 → dir=2.
- dir=12, ball_x=80 (PAD_X+size), ball_y=pad_l_y=960 → dir=4, rally=1; same with pad_l_y=400 → no reflection; then ball_x=16 → score_r pulse, ball_rst=1, next serve gives dir=11.
- Corner: dir=3, ball_y=16, ball_x=2480, pad_r_y=100 → dir=11.
- BALL_SPEEDUP_EN with rally=8, HITS_PER_STEP=4 → 3 move pulses per frame, each 3 cycles apart; an extra frame_tick during stepping is dropped.
- Assert rst between the second and third move pulse → no further move, all outputs at reset values asynchronously.

Source files
------------

// File: rtl/ball_pkg.sv
// Shared constants, FSM encoding and direction-class helpers for the ball sequencer.
package ball_pkg;

    localparam int FIELD_W = 2560;
    localparam int FIELD_H = 1920;

    localparam logic [3:0] DIR_UP    = 4'd0;
    localparam logic [3:0] DIR_RIGHT = 4'd4;
    localparam logic [3:0] DIR_DOWN  = 4'd8;
    localparam logic [3:0] DIR_LEFT  = 4'd12;

    // Serve directions: down-right toward the right player, down-left toward the left.
    localparam logic [3:0] DIR_SERVE_R = 4'd5;
    localparam logic [3:0] DIR_SERVE_L = 4'd11;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_IDLE,
        ST_STEP,
        ST_SETTLE,
        ST_CHECK,
        ST_SCORE
    } state_e;

    function automatic logic is_up(input logic [3:0] d);
        return (d < DIR_RIGHT) || (d > DIR_LEFT);
    endfunction

    function automatic logic is_down(input logic [3:0] d);
        return (d > DIR_RIGHT) && (d < DIR_LEFT);
    endfunction

    function automatic logic is_left(input logic [3:0] d);
        return d > DIR_DOWN;
    endfunction

    function automatic logic is_right(input logic [3:0] d);
        return (d > DIR_UP) && (d < DIR_DOWN);
    endfunction

endpackage

// File: rtl/ball_reflect.sv
// Combinational collision check: walls, paddles and misses, plus the reflected direction.
module ball_reflect
    import ball_pkg::*;
#(
    parameter int PAD_X    = 64,
    parameter int PAD_HALF = 160
) (
    input  logic [12:0] ball_x,
    input  logic [12:0] ball_y,
    input  logic [12:0] size,
    input  logic [12:0] pad_l_y,
    input  logic [12:0] pad_r_y,
    input  logic [3:0]  dir,
    output logic [3:0]  new_dir,
    output logic        hit,
    output logic        miss_l,
    output logic        miss_r
);

    localparam logic [13:0] FW = 14'(FIELD_W);
    localparam logic [13:0] FH = 14'(FIELD_H);
    localparam logic [13:0] PX = 14'(PAD_X);
    localparam logic [13:0] PH = 14'(PAD_HALF);

    logic [13:0] x, y, s, pl, pr;
    logic        wall, pad_l, pad_r;

    assign x  = {1'b0, ball_x};
    assign y  = {1'b0, ball_y};
    assign s  = {1'b0, size};
    assign pl = {1'b0, pad_l_y};
    assign pr = {1'b0, pad_r_y};

    // Bounds are rearranged so nothing is subtracted from the ball position.
    function automatic logic overlap(input logic [13:0] by, input logic [13:0] bs,
                                     input logic [13:0] pad);
        logic [13:0] lo;
        lo = (pad >= PH) ? pad - PH : 14'd0;
        return (by + bs >= lo) && (by <= pad + PH + bs);
    endfunction

    assign wall   = (is_up(dir) && y <= s) || (is_down(dir) && y + s >= FH);
    assign pad_l  = is_left(dir) && (x <= PX + s) && overlap(y, s, pl);
    assign pad_r  = is_right(dir) && (x + s + PX >= FW) && overlap(y, s, pr);
    assign miss_l = is_left(dir) && (x <= s);
    assign miss_r = is_right(dir) && (x + s >= FW);
    assign hit    = (pad_l || pad_r) && !(miss_l || miss_r);

    always_comb begin
        new_dir = dir;
        if (!(miss_l || miss_r)) begin
            if (wall && hit)  new_dir = dir + 4'd8;
            else if (wall)    new_dir = 4'd8 - dir;
            else if (hit)     new_dir = 4'd0 - dir;
        end
    end

endmodule

// File: rtl/ball_ctrl.sv
// Ball physics sequencer: frame tick -> move strobes, collision checks, scoring and serve.
// BALL_SPEEDUP_EN adds rally-based speed-up (more strobes per frame as the rally grows).
module ball_ctrl
    import ball_pkg::*;
#(
    parameter int PAD_X         = 64,
    parameter int PAD_HALF      = 160,
`ifdef BALL_SPEEDUP_EN
    parameter int HITS_PER_STEP = 4,
`endif
    parameter int MAX_STEPS     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        serve,
    input  logic [12:0] ball_x,
    input  logic [12:0] ball_y,
    input  logic [12:0] size,
    input  logic [12:0] pad_l_y,
    input  logic [12:0] pad_r_y,
    output logic        move,
    output logic [3:0]  dir,
    output logic        ball_rst,
    output logic        score_l,
    output logic        score_r,
    output logic        in_play,
    output logic [2:0]  steps
);

    state_e      state_q, state_d;
    logic        move_q, move_d;
    logic [3:0]  dir_q, dir_d;
    logic        ball_rst_q, ball_rst_d;
    logic        score_l_q, score_l_d;
    logic        score_r_q, score_r_d;
    logic        in_play_q, in_play_d;
    logic [2:0]  steps_q, steps_d;
    logic [2:0]  rem_q, rem_d;
    logic [7:0]  rally_q, rally_d;

    logic [3:0]  new_dir;
    logic        hit, miss_l, miss_r;
    logic [7:0]  raw_steps;
    logic [2:0]  step_load;

    ball_reflect #(.PAD_X(PAD_X), .PAD_HALF(PAD_HALF)) u_reflect (
        .ball_x  (ball_x),
        .ball_y  (ball_y),
        .size    (size),
        .pad_l_y (pad_l_y),
        .pad_r_y (pad_r_y),
        .dir     (dir_q),
        .new_dir (new_dir),
        .hit     (hit),
        .miss_l  (miss_l),
        .miss_r  (miss_r)
    );

`ifdef BALL_SPEEDUP_EN
    assign raw_steps = 8'(rally_q / 8'(HITS_PER_STEP)) + 8'd1;
`else
    assign raw_steps = 8'd1;
`endif
    assign step_load = (raw_steps >= 8'(MAX_STEPS)) ? 3'(MAX_STEPS) : raw_steps[2:0];

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        steps_d   = steps_q;
        rem_d     = rem_q;
        rally_d   = rally_q;
        move_d    = 1'b0;
        score_l_d = 1'b0;
        score_r_d = 1'b0;
        case (state_q)
            ST_WAIT:   if (serve) state_d = ST_IDLE;
            ST_IDLE: begin
                if (frame_tick) begin
                    steps_d = step_load;
                    rem_d   = step_load - 3'd1;
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                move_d  = 1'b1;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: state_d = ST_CHECK;
            ST_CHECK: begin
                if (miss_l || miss_r) begin
                    score_r_d = miss_l;
                    score_l_d = miss_r;
                    state_d   = ST_SCORE;
                end else begin
                    dir_d = new_dir;
                    if (hit && rally_q != 8'hff) rally_d = rally_q + 8'd1;
                    if (rem_q != 3'd0) begin
                        rem_d   = rem_q - 3'd1;
                        state_d = ST_STEP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_SCORE: begin
                // The side that conceded receives the next serve.
                dir_d   = score_r_q ? DIR_SERVE_L : DIR_SERVE_R;
                rally_d = 8'd0;
                state_d = ST_WAIT;
            end
            default:   state_d = ST_WAIT;
        endcase
        ball_rst_d = (state_d == ST_WAIT);
        in_play_d  = state_d inside {ST_IDLE, ST_STEP, ST_SETTLE, ST_CHECK};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_WAIT;
            move_q     <= 1'b0;
            dir_q      <= DIR_SERVE_R;
            ball_rst_q <= 1'b1;
            score_l_q  <= 1'b0;
            score_r_q  <= 1'b0;
            in_play_q  <= 1'b0;
            steps_q    <= 3'd1;
            rem_q      <= 3'd0;
            rally_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            move_q     <= move_d;
            dir_q      <= dir_d;
            ball_rst_q <= ball_rst_d;
            score_l_q  <= score_l_d;
            score_r_q  <= score_r_d;
            in_play_q  <= in_play_d;
            steps_q    <= steps_d;
            rem_q      <= rem_d;
            rally_q    <= rally_d;
        end
    end

    assign move     = move_q;
    assign dir      = dir_q;
    assign ball_rst = ball_rst_q;
    assign score_l  = score_l_q;
    assign score_r  = score_r_q;
    assign in_play  = in_play_q;
    assign steps    = steps_q;

endmodule
